// File: rtl/serial_io_pkg.sv
// Shared opcodes, FSM state encoding and error-bit indices for serial_io_hub.
package serial_io_pkg;

    localparam logic [3:0] OP_RX_AVAIL = 4'd0;
    localparam logic [3:0] OP_TX_FULL  = 4'd1;
    localparam logic [3:0] OP_TX_WRITE = 4'd2;
    localparam logic [3:0] OP_RX_READ  = 4'd3;
    localparam logic [3:0] OP_STATUS   = 4'd4;
    localparam logic [3:0] OP_IRQ_MASK = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_POP = 2'd1,
        ST_RD_CAP = 2'd2
    } state_e;

    localparam int ERR_TX_FULL  = 0;
    localparam int ERR_RX_EMPTY = 1;
    localparam int ERR_BAD_CH   = 2;
    localparam int ERR_BUSY     = 3;

endpackage

// File: rtl/serial_io_hub.sv
// Bus-mapped controller for NUM_CH FIFO-backed serial channels with sticky error status.
// Optional SERIAL_IO_HUB_IRQ_EN adds an irq output and the IRQ_MASK opcode.
module serial_io_hub
    import serial_io_pkg::*;
#(
    parameter int BUS_W  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    inout  wire  [BUS_W-1:0]      bus,
    input  logic [2:0]            ctrl,
    input  logic [NUM_CH*8-1:0]   rx_data,
    input  logic [NUM_CH-1:0]     rx_empty,
    output logic [NUM_CH-1:0]     rx_rd,
    output logic [7:0]            tx_data,
    input  logic [NUM_CH-1:0]     tx_full,
    output logic [NUM_CH-1:0]     tx_wr,
`ifdef SERIAL_IO_HUB_IRQ_EN
    output logic                  irq,
`endif
    output logic                  busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e              state_q, state_d;
    logic [BUS_W-1:0]    io_q, io_d;
    logic [3:0]          err_q, err_d;
    logic [NUM_CH-1:0]   rx_rd_q, rx_rd_d;
    logic [NUM_CH-1:0]   tx_wr_q, tx_wr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
`ifdef SERIAL_IO_HUB_IRQ_EN
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                irq_q, irq_d;
`endif

    logic [3:0]          opcode;
    logic [3:0]          ch_raw;
    logic [CH_W-1:0]     ch;
    logic                ch_ok;
    logic [NUM_CH-1:0]   ch_onehot;
    logic [7:0]          cap_byte;
    logic [3:0]          err_set;
    logic                err_clr;

    // The full nibble is decoded so selects beyond NUM_CH are flagged, not aliased.
    assign opcode = bus[3:0];
    assign ch_raw = bus[7:4];
    assign ch     = ch_raw[CH_W-1:0];
    assign ch_ok  = ({28'd0, ch_raw} < 32'(NUM_CH));

    always_comb begin
        ch_onehot = '0;
        cap_byte  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_onehot[i] = (ch == i[CH_W-1:0]);
            if (ch_q == i[CH_W-1:0]) begin
                cap_byte = rx_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        io_d    = io_q;
        ch_d    = ch_q;
        rx_rd_d = '0;
        tx_wr_d = '0;
        err_set = '0;
        err_clr = 1'b0;
`ifdef SERIAL_IO_HUB_IRQ_EN
        mask_d  = mask_q;
        irq_d   = |(~rx_empty & mask_q);
`endif
        case (state_q)
            ST_IDLE: begin
                if (!ctrl[1]) begin
                    if (ctrl[2]) begin
                        if (!ch_ok) begin
                            err_set[ERR_BAD_CH] = 1'b1;
                        end else begin
                            case (opcode)
                                OP_RX_AVAIL: io_d = {{(BUS_W-1){1'b0}}, ~rx_empty[ch]};
                                OP_TX_FULL:  io_d = {{(BUS_W-1){1'b0}}, tx_full[ch]};
                                OP_TX_WRITE: begin
                                    if (tx_full[ch]) err_set[ERR_TX_FULL] = 1'b1;
                                    else             tx_wr_d = ch_onehot;
                                end
                                OP_RX_READ: begin
                                    if (rx_empty[ch]) begin
                                        io_d = '0;
                                        err_set[ERR_RX_EMPTY] = 1'b1;
                                    end else begin
                                        state_d = ST_RD_POP;
                                        rx_rd_d = ch_onehot;
                                        ch_d    = ch;
                                    end
                                end
                                OP_STATUS: begin
                                    io_d    = {{(BUS_W-4){1'b0}}, err_q};
                                    err_clr = 1'b1;
                                end
`ifdef SERIAL_IO_HUB_IRQ_EN
                                OP_IRQ_MASK: mask_d = io_q[NUM_CH-1:0];
`endif
                                default: ;
                            endcase
                        end
                    end else if (ctrl[0]) begin
                        io_d = bus;
                    end
                end
            end
            ST_RD_POP: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                // FIFO output is valid the cycle after the pop strobe.
                state_d = ST_IDLE;
                io_d    = {{(BUS_W-8){1'b0}}, cap_byte};
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q != ST_IDLE) && (ctrl[2] || ctrl[0])) begin
            err_set[ERR_BUSY] = 1'b1;
        end
        // A new error in the same cycle as a STATUS read survives the clear.
        err_d = (err_clr ? 4'd0 : err_q) | err_set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            io_q    <= '0;
            err_q   <= '0;
            ch_q    <= '0;
            rx_rd_q <= '0;
            tx_wr_q <= '0;
`ifdef SERIAL_IO_HUB_IRQ_EN
            mask_q  <= '0;
            irq_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            io_q    <= io_d;
            err_q   <= err_d;
            ch_q    <= ch_d;
            rx_rd_q <= rx_rd_d;
            tx_wr_q <= tx_wr_d;
`ifdef SERIAL_IO_HUB_IRQ_EN
            mask_q  <= mask_d;
            irq_q   <= irq_d;
`endif
        end
    end

    assign bus     = ctrl[1] ? io_q : {BUS_W{1'bz}};
    assign tx_data = io_q[7:0];
    assign rx_rd   = rx_rd_q;
    assign tx_wr   = tx_wr_q;
    assign busy    = (state_q != ST_IDLE);
`ifdef SERIAL_IO_HUB_IRQ_EN
    assign irq     = irq_q;
`endif

endmodule
